// File: rtl/dmem_ws.sv
// Word-organised data memory with a req/busy/ack handshake, a fixed number of
// wait states, byte-lane writes and misaligned/out-of-range error reporting.
module dmem_ws #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   wd,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   rd,
  output logic                    ack,
  output logic                    err,
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  localparam int IW = $clog2(DEPTH);
  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(DEPTH * NB);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Handshake: req (with we/a/wd/be) is taken only on an edge where busy=0;
  // busy then stays high until the single-cycle ack (with err and rd) has
  // been presented, and req is ignored throughout that window.
  state_t                  state_q, state_d;
  logic [3:0]              cnt_q;
  logic                    rst_done;
  logic                    cap_we;
  logic [ADDR_WIDTH-1:0]   cap_a;
  logic [DATA_WIDTH-1:0]   cap_wd;
  logic [NB-1:0]           cap_be;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    start;
  logic                    do_access;
  logic                    addr_err;
  logic [IW-1:0]           widx;

  // rst_done blocks capture on the first edge after reset release, so a req
  // arriving together with the release is never taken.
  assign start     = (state_q == IDLE) && req && rst_done;
  assign do_access = (state_q == WAIT) && (cnt_q == 4'd0);
  assign addr_err  = (cap_a[1:0] != 2'b00) || ({1'b0, cap_a} >= LIMIT);
  assign widx      = cap_a[IW+1:2];
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req && rst_done) state_d = WAIT;
      WAIT:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      rst_done <= 1'b0;
      ack      <= 1'b0;
      err      <= 1'b0;
      rd       <= '0;
      cap_we   <= 1'b0;
      cap_a    <= '0;
      cap_wd   <= '0;
      cap_be   <= '0;
    end else begin
      state_q  <= state_d;
      rst_done <= 1'b1;
      ack      <= do_access;
      err      <= do_access && addr_err;
      if (start) begin
        cnt_q  <= 4'(LATENCY);
        cap_we <= we;
        cap_a  <= a;
        cap_wd <= wd;
        cap_be <= be;
      end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (do_access && !cap_we && !addr_err) rd <= mem[widx];
    end
  end

  // The array is deliberately left out of reset; a reset before the access
  // edge leaves state_q in IDLE so a pending write never lands.
  always_ff @(posedge clk) begin
    if (do_access && cap_we && !addr_err) begin
      for (int i = 0; i < NB; i++) begin
        if (cap_be[i]) mem[widx][8*i +: 8] <= cap_wd[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ws.sv
// Bench for dmem_ws: three instances (LATENCY 2, 0, 15) driven independently,
// checked every cycle against a transaction-timing model plus literal checks.
module tb_dmem_ws;

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : (g == 1) ? 0 : 15;
  endfunction

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req [3];
  logic        we [3];
  logic [31:0] a [3];
  logic [31:0] wd [3];
  logic [3:0]  be [3];
  logic [31:0] rd [3];
  logic        ack [3];
  logic        err [3];
  logic        busy [3];
  logic [1:0]  dbg_state [3];

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_ws #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(32),
      .DEPTH(64),
      .LATENCY(lat_of(g))
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .req(req[g]),
      .we(we[g]),
      .a(a[g]),
      .wd(wd[g]),
      .be(be[g]),
      .rd(rd[g]),
      .ack(ack[g]),
      .err(err[g]),
      .busy(busy[g]),
      .dbg_state(dbg_state[g])
    );
  end

  function automatic void chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] @%0t: got %h expected %h", nm, k, $time, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // An access captured at edge c completes at edge c+L+1 and busy drops after
  // edge c+L+2; only then can another request be taken.
  int          cyc = 0;
  bit          armed = 1'b0;
  bit          pend [3] = '{0, 0, 0};
  int          cap_e [3];
  logic        m_we [3];
  logic [31:0] m_a [3];
  logic [31:0] m_wd [3];
  logic [3:0]  m_be [3];
  logic        e_busy [3] = '{0, 0, 0};
  logic        e_ack [3] = '{0, 0, 0};
  logic        e_err [3] = '{0, 0, 0};
  logic [31:0] e_rd [3] = '{0, 0, 0};
  logic [31:0] mem_m [3][64];

  task automatic model_edge(input int k);
    int  l;
    bit  was_idle;
    bit  bad;
    l = lat_of(k);
    was_idle = !pend[k];
    e_ack[k] = 1'b0;
    if (pend[k] && cyc == cap_e[k] + l + 1) begin
      bad = (m_a[k] % 4 != 0) || (m_a[k] >= 32'd256);
      e_ack[k] = 1'b1;
      e_err[k] = bad;
      if (!bad) begin
        if (m_we[k]) begin
          for (int i = 0; i < 4; i++)
            if (m_be[k][i]) mem_m[k][m_a[k] / 4][8*i +: 8] = m_wd[k][8*i +: 8];
        end else begin
          e_rd[k] = mem_m[k][m_a[k] / 4];
        end
      end
    end
    if (pend[k] && cyc == cap_e[k] + l + 2) pend[k] = 1'b0;
    if (was_idle && req[k]) begin
      pend[k] = 1'b1;
      cap_e[k] = cyc;
      m_we[k] = we[k];
      m_a[k]  = a[k];
      m_wd[k] = wd[k];
      m_be[k] = be[k];
    end
    e_busy[k] = pend[k];
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed = 1'b0;
      for (int k = 0; k < 3; k++) begin
        pend[k] = 1'b0;
        e_busy[k] = 1'b0;
        e_ack[k] = 1'b0;
        e_err[k] = 1'b0;
        e_rd[k] = 32'h0;
      end
    end else begin
      cyc++;
      if (!armed) armed = 1'b1;
      else for (int k = 0; k < 3; k++) model_edge(k);
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk("busy", k, 32'(busy[k]), 32'(e_busy[k]));
      chk("ack", k, 32'(ack[k]), 32'(e_ack[k]));
      chk("rd", k, rd[k], e_rd[k]);
      if (e_ack[k]) chk("err", k, 32'(err[k]), 32'(e_err[k]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_acc(input int k, input logic w, input logic [31:0] ad, input logic [31:0] dat,
                        input logic [3:0] b, output logic [31:0] r, output logic e,
                        output int lat, output int bcyc);
    int t;
    t = 0;
    while (busy[k] && t < 100) begin @(posedge clk); #1; t++; end
    chk("idle_timeout", k, 32'(t < 100), 32'd1);
    req[k] = 1'b1; we[k] = w; a[k] = ad; wd[k] = dat; be[k] = b;
    @(posedge clk); #1;
    req[k] = 1'b0; we[k] = ~w; a[k] = $urandom; wd[k] = $urandom; be[k] = 4'($urandom);
    lat = 0; bcyc = 0;
    while (!ack[k] && lat < 100) begin
      if (busy[k]) bcyc++;
      @(posedge clk); #1; lat++;
    end
    chk("ack_timeout", k, 32'(lat < 100), 32'd1);
    r = rd[k]; e = err[k];
    if (busy[k]) bcyc++;
    @(posedge clk); #1;
    chk("ack_pulse", k, 32'(ack[k]), 32'd0);
    while (busy[k] && bcyc < 100) begin bcyc++; @(posedge clk); #1; end
  endtask

  task automatic preload(input int k);
    logic [31:0] r; logic e; int l, bc;
    for (int i = 0; i < 64; i++) do_acc(k, 1'b1, 32'(i * 4), $urandom, 4'hF, r, e, l, bc);
  endtask

  task automatic rand_run(input int k, input int n);
    logic [31:0] r, ad; logic e; int l, bc, mode;
    for (int i = 0; i < n; i++) begin
      mode = $urandom_range(0, 7);
      ad = 32'($urandom_range(0, 63)) * 4;
      if (mode == 0) ad = ad + 32'($urandom_range(1, 3));
      else if (mode == 1) ad = 32'd256 + 32'($urandom_range(0, 1000)) * 4;
      do_acc(k, 1'($urandom), ad, $urandom, 4'($urandom), r, e, l, bc);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] r; logic e; int l, bc; logic prev;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; a[k] = 32'h0; wd[k] = 32'h0; be[k] = 4'h0;
    end
    #1 reset = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", k, 32'(busy[k]), 32'd0);
      chk("rst_ack", k, 32'(ack[k]), 32'd0);
      chk("rst_err", k, 32'(err[k]), 32'd0);
      chk("rst_rd", k, rd[k], 32'd0);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    fork preload(0); preload(1); preload(2); join

    // basic write/read at LATENCY 2
    do_acc(0, 1'b1, 32'h00, 32'h12345678, 4'hF, r, e, l, bc);
    do_acc(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, r, e, l, bc);
    chk("wr_latency", 0, 32'(l), 32'd3);
    chk("wr_err", 0, 32'(e), 32'd0);
    do_acc(0, 1'b0, 32'h10, 32'h0, 4'h0, r, e, l, bc);
    chk("rd_latency", 0, 32'(l), 32'd3);
    chk("rd_data", 0, r, 32'hDEADBEEF);
    chk("rd_err", 0, 32'(e), 32'd0);

    // byte lanes
    do_acc(0, 1'b1, 32'h20, 32'h11223344, 4'hF, r, e, l, bc);
    do_acc(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, r, e, l, bc);
    do_acc(0, 1'b0, 32'h20, 32'h0, 4'h0, r, e, l, bc);
    chk("lane_data", 0, r, 32'h11BB33DD);
    do_acc(0, 1'b1, 32'h20, 32'h55555555, 4'h0, r, e, l, bc);
    chk("be0_err", 0, 32'(e), 32'd0);
    do_acc(0, 1'b0, 32'h20, 32'h0, 4'hF, r, e, l, bc);
    chk("be0_data", 0, r, 32'h11BB33DD);

    // errors
    do_acc(0, 1'b0, 32'h13, 32'h0, 4'hF, r, e, l, bc);
    chk("mis_err", 0, 32'(e), 32'd1);
    chk("mis_rd_held", 0, r, 32'h11BB33DD);
    do_acc(0, 1'b1, 32'h100, 32'hCAFEF00D, 4'hF, r, e, l, bc);
    chk("oor_err", 0, 32'(e), 32'd1);
    chk("oor_rd_held", 0, r, 32'h11BB33DD);
    do_acc(0, 1'b0, 32'h00, 32'h0, 4'h0, r, e, l, bc);
    chk("post_err_data", 0, r, 32'h12345678);
    chk("post_err_err", 0, 32'(e), 32'd0);

    // latency sweep
    do_acc(1, 1'b1, 32'h04, 32'h0BADC0DE, 4'hF, r, e, l, bc);
    chk("l0_latency", 1, 32'(l), 32'd1);
    chk("l0_busy", 1, 32'(bc), 32'd2);
    do_acc(2, 1'b0, 32'h04, 32'h0, 4'h0, r, e, l, bc);
    chk("l15_latency", 2, 32'(l), 32'd16);
    chk("l15_busy", 2, 32'(bc), 32'd17);

    // req held high with live inputs changing every cycle
    prev = 1'b0;
    req[0] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      we[0] = 1'($urandom); a[0] = 32'($urandom_range(0, 63)) * 4;
      wd[0] = $urandom; be[0] = 4'($urandom);
      @(posedge clk); #1;
      chk("ack_run", 0, 32'(prev && ack[0]), 32'd0);
      prev = ack[0];
    end
    req[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // reset during the wait of a write, then release together with a req
    do_acc(0, 1'b1, 32'h08, 32'h0, 4'hF, r, e, l, bc);
    req[0] = 1'b1; we[0] = 1'b1; a[0] = 32'h08; wd[0] = 32'hFFFFFFFF; be[0] = 4'hF;
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 0, 32'(busy[0]), 32'd0);
    chk("mid_rst_ack", 0, 32'(ack[0]), 32'd0);
    chk("mid_rst_rd", 0, rd[0], 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1; req[0] = 1'b1; we[0] = 1'b0; a[0] = 32'h08;
    @(posedge clk); #1;
    chk("release_no_capture", 0, 32'(busy[0]), 32'd0);
    @(posedge clk); #1;
    chk("first_capture", 0, 32'(busy[0]), 32'd1);
    req[0] = 1'b0;
    l = 0;
    while (!ack[0] && l < 100) begin @(posedge clk); #1; l++; end
    chk("rst_rd_latency", 0, 32'(l), 32'd3);
    chk("rst_wr_discarded", 0, rd[0], 32'h0);
    repeat (2) @(posedge clk);
    #1;

    // randomized traffic
    fork rand_run(0, 40); rand_run(1, 40); rand_run(2, 25); join
    repeat (4) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_checks++;
    n_fail++;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
